// File: rtl/axi_llc_desc_merger_pkg.sv
// rtl/axi_llc_desc_merger_pkg.sv - shared types for the LLC descriptor merger
package axi_llc_desc_merger_pkg;

  typedef struct packed {
    logic [7:0]  tag;
    logic [23:0] addr;
    logic        x_last;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } merge_state_e;

endpackage

// File: rtl/axi_llc_desc_merger_if.sv
// rtl/axi_llc_desc_merger_if.sv - valid/ready descriptor channel
interface axi_llc_desc_merger_if;
  import axi_llc_desc_merger_pkg::*;

  desc_t desc;
  logic  valid;
  logic  ready;

  modport master (output desc, output valid, input ready);
  modport slave  (input desc, input valid, output ready);

endinterface

// File: rtl/axi_llc_desc_merger.sv
// rtl/axi_llc_desc_merger.sv - merges W, R and flush descriptors into one registered stream
module axi_llc_desc_merger
  import axi_llc_desc_merger_pkg::*;
#(
  parameter bit PrioWrite = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  axi_llc_desc_merger_if.slave          w_i,
  axi_llc_desc_merger_if.slave          r_i,
  axi_llc_desc_merger_if.slave          flush_i,
  axi_llc_desc_merger_if.master         desc_o,
  output logic                          flush_pend_o
);

  merge_state_e state_q, state_d;
  logic         w_burst_q, w_burst_d;
  logic         r_burst_q, r_burst_d;
  logic         prio_q, prio_d;
  logic         valid_q, valid_d;
  desc_t        desc_q, desc_d;

  logic load_en;
  logic w_ok, r_ok, w_req, r_req;
  logic w_ready, r_ready, f_ready;
  logic w_gnt, r_gnt, f_gnt;

  always_comb begin
    state_d   = state_q;
    w_burst_d = w_burst_q;
    r_burst_d = r_burst_q;
    prio_d    = prio_q;
    valid_d   = valid_q;
    desc_d    = desc_q;
    w_ready   = 1'b0;
    r_ready   = 1'b0;
    f_ready   = 1'b0;

    load_en = !valid_q || desc_o.ready;

    // In DRAIN only an already-open burst may continue, so no new burst starts ahead of the flush.
    w_ok  = (state_q == IDLE) || ((state_q == DRAIN) && w_burst_q);
    r_ok  = (state_q == IDLE) || ((state_q == DRAIN) && r_burst_q);
    w_req = w_ok && w_i.valid;
    r_req = r_ok && r_i.valid;

    // Each ready looks only at the competing source's request, never at its own valid.
    if (load_en) begin
      if (state_q == FLUSH) begin
        f_ready = 1'b1;
      end else begin
        w_ready = w_ok && (prio_q || !r_req);
        r_ready = r_ok && (!prio_q || !w_req);
      end
    end

    w_gnt = w_ready && w_i.valid;
    r_gnt = r_ready && r_i.valid;
    f_gnt = f_ready && flush_i.valid;

    if (load_en) begin
      valid_d = w_gnt || r_gnt || f_gnt;
    end

    if (w_gnt) begin
      desc_d    = w_i.desc;
      w_burst_d = !w_i.desc.x_last;
      prio_d    = 1'b0;
    end else if (r_gnt) begin
      desc_d    = r_i.desc;
      r_burst_d = !r_i.desc.x_last;
      prio_d    = 1'b1;
    end else if (f_gnt) begin
      desc_d    = flush_i.desc;
    end

    case (state_q)
      IDLE: begin
        if (flush_i.valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Next-state burst flags let a last beat granted now open FLUSH on the very next cycle.
        if (!flush_i.valid) begin
          state_d = IDLE;
        end else if (!w_burst_d && !r_burst_d) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (f_gnt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      w_burst_q <= 1'b0;
      r_burst_q <= 1'b0;
      prio_q    <= PrioWrite;
      valid_q   <= 1'b0;
      desc_q    <= '0;
    end else begin
      state_q   <= state_d;
      w_burst_q <= w_burst_d;
      r_burst_q <= r_burst_d;
      prio_q    <= prio_d;
      valid_q   <= valid_d;
      desc_q    <= desc_d;
    end
  end

  assign w_i.ready     = w_ready;
  assign r_i.ready     = r_ready;
  assign flush_i.ready = f_ready;
  assign desc_o.valid  = valid_q;
  assign desc_o.desc   = desc_q;
  assign flush_pend_o  = (state_q != IDLE);

  a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_q && !desc_o.ready) |=> (valid_q && $stable(desc_q)));

  a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({w_gnt, r_gnt, f_gnt}));

  a_flush_last: assert property (@(posedge clk_i) disable iff (!rst_ni)
    f_gnt |-> flush_i.desc.x_last);

  a_flush_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == FLUSH) |-> flush_i.valid);

endmodule
